conv_channel_scheduler: RTL and testbench

Sequencer and accumulator for the 8-lane signed MAC engine. On a start command it walks every (output channel, input-channel group) pair, drives the engine's `input_channel_sel`, `output_channel_sel`, `input_channel_done` and `output_channel_done` inputs one beat per cycle, and tracks each beat through the engine's fixed pipeline latency. It sums the engine's partial results into one full-width total per output channel, which it emits on a valid strobe. It sits between the layer control register block and the compute engine plus its data/weight fetch path.

---
 rtl/conv_channel_scheduler_if.sv | 36 +++
 rtl/conv_channel_scheduler.sv | 158 +++++++++++++++
 tb/tb_conv_channel_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_channel_scheduler_if.sv
// Handshake and data bus between the layer controller, the MAC engine and conv_channel_scheduler.
interface conv_channel_scheduler_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 32
);
    localparam int unsigned CNT_WIDTH = 8;
    localparam int unsigned RES_WIDTH = 2 * DATA_WIDTH;

    logic                        start;
    logic [CNT_WIDTH-1:0]        num_in_groups;
    logic [CNT_WIDTH-1:0]        num_out_ch;
    logic                        fetch_ready;
    logic signed [RES_WIDTH-1:0] eng_result;
    logic                        fetch_valid;
    logic [CNT_WIDTH-1:0]        input_channel_sel;
    logic [CNT_WIDTH-1:0]        output_channel_sel;
    logic                        input_channel_done;
    logic                        output_channel_done;
    logic                        busy;
    logic                        done;
    logic                        acc_valid;
    logic [CNT_WIDTH-1:0]        acc_out_ch;
    logic signed [ACC_WIDTH-1:0] acc_data;

    modport master (
        output start, num_in_groups, num_out_ch, fetch_ready, eng_result,
        input  fetch_valid, input_channel_sel, output_channel_sel, input_channel_done,
               output_channel_done, busy, done, acc_valid, acc_out_ch, acc_data
    );

    modport slave (
        input  start, num_in_groups, num_out_ch, fetch_ready, eng_result,
        output fetch_valid, input_channel_sel, output_channel_sel, input_channel_done,
               output_channel_done, busy, done, acc_valid, acc_out_ch, acc_data
    );
endinterface

// File: rtl/conv_channel_scheduler.sv
// Walks (output channel, input group) beats into the MAC engine and accumulates per-channel totals.
// Define SCHED_SATURATE_EN to clamp the accumulator instead of wrapping.
module conv_channel_scheduler #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ACC_WIDTH      = 32,
    parameter int unsigned ENGINE_LATENCY = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    conv_channel_scheduler_if.slave  bus
);
    localparam int unsigned CNT_WIDTH = 8;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic                 valid;
        logic                 last;
        logic [CNT_WIDTH-1:0] oc;
    } tag_t;

    state_t                      state;
    logic [CNT_WIDTH-1:0]        n_groups;
    logic [CNT_WIDTH-1:0]        n_out;
    logic [CNT_WIDTH-1:0]        ic;
    logic [CNT_WIDTH-1:0]        oc;
    tag_t                        tag_pipe [ENGINE_LATENCY];
    logic signed [ACC_WIDTH-1:0] run_sum;

    logic                        issue_c;
    logic                        ic_last_c;
    logic                        oc_last_c;
    logic                        pipe_busy_c;
    tag_t                        exit_tag_c;
    logic signed [ACC_WIDTH-1:0] next_sum_c;

    // Issue is combinational on fetch_ready so a stalled cycle never advances the walk.
    assign issue_c   = (state == RUN) && bus.fetch_ready;
    assign ic_last_c = (ic == n_groups - 8'd1);
    assign oc_last_c = (oc == n_out - 8'd1);

    assign bus.fetch_valid         = issue_c;
    assign bus.input_channel_sel   = ic;
    assign bus.output_channel_sel  = oc;
    assign bus.input_channel_done  = issue_c && ic_last_c;
    assign bus.output_channel_done = issue_c && ic_last_c && oc_last_c;

    assign exit_tag_c = tag_pipe[ENGINE_LATENCY-1];

    always_comb begin
        pipe_busy_c = 1'b0;
        for (int unsigned i = 0; i < ENGINE_LATENCY; i++) begin
            pipe_busy_c = pipe_busy_c | tag_pipe[i].valid;
        end
    end

`ifdef SCHED_SATURATE_EN
    localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [SUM_WIDTH-1:0] wide_sum_c;

    // One guard bit exposes overflow; clamp toward the sign of the true result.
    always_comb begin
        wide_sum_c = SUM_WIDTH'(run_sum) + SUM_WIDTH'(bus.eng_result);
        next_sum_c = wide_sum_c[ACC_WIDTH-1:0];
        if (wide_sum_c[ACC_WIDTH] != wide_sum_c[ACC_WIDTH-1]) begin
            next_sum_c = wide_sum_c[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign next_sum_c = run_sum + ACC_WIDTH'(bus.eng_result);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            n_groups       <= '0;
            n_out          <= '0;
            ic             <= '0;
            oc             <= '0;
            run_sum        <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.acc_valid  <= 1'b0;
            bus.acc_out_ch <= '0;
            bus.acc_data   <= '0;
            for (int unsigned i = 0; i < ENGINE_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            bus.done      <= 1'b0;
            bus.acc_valid <= 1'b0;

            // Tags shift every cycle; stalls push bubbles so latency stays fixed.
            tag_pipe[0] <= '{valid: issue_c, last: issue_c && ic_last_c, oc: oc};
            for (int unsigned i = 1; i < ENGINE_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end

            if (exit_tag_c.valid) begin
                if (exit_tag_c.last) begin
                    bus.acc_valid  <= 1'b1;
                    bus.acc_data   <= next_sum_c;
                    bus.acc_out_ch <= exit_tag_c.oc;
                    run_sum        <= '0;
                end else begin
                    run_sum <= next_sum_c;
                end
            end

            if (issue_c) begin
                if (ic_last_c) begin
                    ic <= '0;
                    oc <= oc_last_c ? '0 : oc + 8'd1;
                end else begin
                    ic <= ic + 8'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        n_groups <= bus.num_in_groups;
                        n_out    <= bus.num_out_ch;
                        ic       <= '0;
                        oc       <= '0;
                        bus.busy <= 1'b1;
                        if ((bus.num_in_groups == 8'd0) || (bus.num_out_ch == 8'd0)) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue_c && ic_last_c && oc_last_c) begin
                        state <= DRAIN;
                    end
                end
                // Pipe empties in the same cycle the final total is presented.
                DRAIN: begin
                    if (!pipe_busy_c) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_channel_scheduler.sv
// Directed self-checking bench for conv_channel_scheduler; a 16-bit accumulator copy covers overflow.
module tb_conv_channel_scheduler;
    localparam int DW  = 8;
    localparam int LAT = 4;
    localparam int LOG = 40;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t0 = -1000;
    int   rel;

    always #5 clk = ~clk;

    conv_channel_scheduler_if #(.DATA_WIDTH(DW), .ACC_WIDTH(32)) bus ();
    conv_channel_scheduler_if #(.DATA_WIDTH(DW), .ACC_WIDTH(16)) bus_n ();

    conv_channel_scheduler #(.DATA_WIDTH(DW), .ACC_WIDTH(32), .ENGINE_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    conv_channel_scheduler #(.DATA_WIDTH(DW), .ACC_WIDTH(16), .ENGINE_LATENCY(LAT)) dut_n (
        .clk(clk), .rst(rst), .bus(bus_n)
    );

    assign bus_n.start         = bus.start;
    assign bus_n.num_in_groups = bus.num_in_groups;
    assign bus_n.num_out_ch    = bus.num_out_ch;
    assign bus_n.fetch_ready   = bus.fetch_ready;
    assign bus_n.eng_result    = bus.eng_result;

    // Engine model: value chosen by the beat's (oc, ic), delivered LAT cycles later.
    logic signed [15:0] val_tab [8][8];
    logic signed [15:0] eng_pipe [LAT];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        eng_pipe[0] <= bus.fetch_valid ?
            val_tab[bus.output_channel_sel[2:0]][bus.input_channel_sel[2:0]] : 16'sd0;
        for (int i = 1; i < LAT; i++) eng_pipe[i] <= eng_pipe[i-1];
    end
    assign bus.eng_result = eng_pipe[LAT-1];

    // Per-cycle log relative to the start cycle of the current pass.
    assign rel = cyc - t0;
    logic               fv_log [LOG], icd_log [LOG], ocd_log [LOG];
    logic               av_log [LOG], dn_log [LOG], bsy_log [LOG];
    logic [7:0]         ics_log [LOG], ocs_log [LOG], aoc_log [LOG];
    logic signed [31:0] ad_log [LOG];
    logic signed [15:0] adn_log [LOG];

    always @(negedge clk) begin
        if (rel >= 0 && rel < LOG) begin
            fv_log[rel]  <= bus.fetch_valid;
            icd_log[rel] <= bus.input_channel_done;
            ocd_log[rel] <= bus.output_channel_done;
            av_log[rel]  <= bus.acc_valid;
            dn_log[rel]  <= bus.done;
            bsy_log[rel] <= bus.busy;
            ics_log[rel] <= bus.input_channel_sel;
            ocs_log[rel] <= bus.output_channel_sel;
            aoc_log[rel] <= bus.acc_out_ch;
            ad_log[rel]  <= bus.acc_data;
            adn_log[rel] <= bus_n.acc_data;
        end
    end

    task automatic fill_tab(input logic signed [15:0] v);
        for (int o = 0; o < 8; o++)
            for (int i = 0; i < 8; i++) val_tab[o][i] = v;
    endtask

    // Start at relative cycle 0 and run LOG cycles; optional stall window, reset and stray start.
    task automatic run_pass(input int groups, input int outch, input int stall_at,
                            input int stall_len, input int rst_at, input int restart_at);
        @(posedge clk); #1;
        t0 = cyc;
        bus.start = 1'b1;
        bus.num_in_groups = 8'(groups);
        bus.num_out_ch = 8'(outch);
        bus.fetch_ready = 1'b1;
        rst = 1'b0;
        for (int r = 1; r < LOG; r++) begin
            @(posedge clk); #1;
            bus.start = (r == restart_at);
            bus.fetch_ready = !(r >= stall_at && r < stall_at + stall_len);
            rst = (r == rst_at);
        end
        @(negedge clk); #1;
        bus.start = 1'b0;
        bus.fetch_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.num_in_groups = 8'd0;
        bus.num_out_ch = 8'd0;
        bus.fetch_ready = 1'b0;
        fill_tab(16'sd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if ({bus.fetch_valid, bus.input_channel_done, bus.output_channel_done, bus.busy,
             bus.done, bus.acc_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000", {bus.fetch_valid,
                     bus.input_channel_done, bus.output_channel_done, bus.busy, bus.done, bus.acc_valid});
        end
        checks++;
        if ({bus.input_channel_sel, bus.output_channel_sel, bus.acc_out_ch} !== 24'd0) begin
            errors++;
            $display("FAIL reset_sel ic %0d oc %0d aoc %0d want 0", bus.input_channel_sel,
                     bus.output_channel_sel, bus.acc_out_ch);
        end
        checks++;
        if (bus.acc_data !== 32'sd0 || bus_n.acc_data !== 16'sd0) begin
            errors++;
            $display("FAIL reset_acc got %0d/%0d want 0", bus.acc_data, bus_n.acc_data);
        end
    endtask

    task automatic test_basic;
        logic [5:0] g, e;
        fill_tab(16'sd5);
        run_pass(3, 2, 0, 0, -1, -1);
        for (int r = 0; r < LOG; r++) begin
            g = {fv_log[r], icd_log[r], ocd_log[r], av_log[r], dn_log[r], bsy_log[r]};
            e = {r >= 1 && r <= 6, r == 3 || r == 6, r == 6, r == 8 || r == 11, r == 12,
                 r >= 1 && r <= 12};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL basic_flags cycle %0d got %b want %b", r, g, e);
            end
        end
        for (int r = 1; r <= 6; r++) begin
            checks++;
            if (ics_log[r] !== 8'((r - 1) % 3) || ocs_log[r] !== 8'((r - 1) / 3)) begin
                errors++;
                $display("FAIL basic_sel cycle %0d got ic %0d oc %0d want ic %0d oc %0d", r,
                         ics_log[r], ocs_log[r], (r - 1) % 3, (r - 1) / 3);
            end
        end
        checks++;
        if (ad_log[8] !== 32'sd15 || aoc_log[8] !== 8'd0 || ad_log[11] !== 32'sd15 ||
            aoc_log[11] !== 8'd1) begin
            errors++;
            $display("FAIL basic_totals got (%0d,%0d) (%0d,%0d) want (0,15) (1,15)",
                     aoc_log[8], ad_log[8], aoc_log[11], ad_log[11]);
        end
    endtask

    task automatic test_stall;
        logic [5:0] g, e;
        fill_tab(16'sd5);
        run_pass(3, 2, 3, 2, -1, -1);
        for (int r = 0; r < LOG; r++) begin
            g = {fv_log[r], icd_log[r], ocd_log[r], av_log[r], dn_log[r], bsy_log[r]};
            e = {r == 1 || r == 2 || (r >= 5 && r <= 8), r == 5 || r == 8, r == 8,
                 r == 10 || r == 13, r == 14, r >= 1 && r <= 14};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL stall_flags cycle %0d got %b want %b", r, g, e);
            end
        end
        checks++;
        if (ics_log[3] !== 8'd2 || ocs_log[3] !== 8'd0 || ics_log[4] !== 8'd2 ||
            ocs_log[4] !== 8'd0) begin
            errors++;
            $display("FAIL stall_hold got ic %0d/%0d oc %0d/%0d want ic 2 oc 0",
                     ics_log[3], ics_log[4], ocs_log[3], ocs_log[4]);
        end
        checks++;
        if (ad_log[10] !== 32'sd15 || aoc_log[10] !== 8'd0 || ad_log[13] !== 32'sd15 ||
            aoc_log[13] !== 8'd1) begin
            errors++;
            $display("FAIL stall_totals got (%0d,%0d) (%0d,%0d) want (0,15) (1,15)",
                     aoc_log[10], ad_log[10], aoc_log[13], ad_log[13]);
        end
    endtask

    task automatic test_signed;
        logic [5:0] g, e;
        fill_tab(16'sd0);
        val_tab[0][0] = -16'sd100;
        val_tab[0][1] = 16'sd30;
        val_tab[0][2] = -16'sd7;
        val_tab[0][3] = 16'sd2;
        run_pass(4, 1, 0, 0, -1, -1);
        for (int r = 0; r < LOG; r++) begin
            g = {fv_log[r], icd_log[r], ocd_log[r], av_log[r], dn_log[r], bsy_log[r]};
            e = {r >= 1 && r <= 4, r == 4, r == 4, r == 9, r == 10, r >= 1 && r <= 10};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL signed_flags cycle %0d got %b want %b", r, g, e);
            end
        end
        checks++;
        if (ad_log[9] !== -32'sd75 || aoc_log[9] !== 8'd0) begin
            errors++;
            $display("FAIL signed_total got oc %0d data %0d want oc 0 data -75", aoc_log[9], ad_log[9]);
        end
    endtask

    task automatic test_zero;
        logic [5:0] g, e;
        fill_tab(16'sd9);
        run_pass(0, 5, 0, 0, -1, -1);
        for (int r = 0; r < LOG; r++) begin
            g = {fv_log[r], icd_log[r], ocd_log[r], av_log[r], dn_log[r], bsy_log[r]};
            e = {3'b000, 1'b0, r == 1, r == 1};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL zero_flags cycle %0d got %b want %b", r, g, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] g, e;
        fill_tab(16'sd0);
        val_tab[0][0] = 16'sd10;
        val_tab[1][0] = -16'sd20;
        val_tab[2][0] = 16'sd30;
        run_pass(1, 3, 0, 0, -1, 3);
        for (int r = 0; r < LOG; r++) begin
            g = {fv_log[r], icd_log[r], ocd_log[r], av_log[r], dn_log[r], bsy_log[r]};
            e = {r >= 1 && r <= 3, r >= 1 && r <= 3, r == 3, r >= 6 && r <= 8, r == 9,
                 r >= 1 && r <= 9};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL b2b_flags cycle %0d got %b want %b", r, g, e);
            end
        end
        checks++;
        if (aoc_log[6] !== 8'd0 || ad_log[6] !== 32'sd10 || aoc_log[7] !== 8'd1 ||
            ad_log[7] !== -32'sd20 || aoc_log[8] !== 8'd2 || ad_log[8] !== 32'sd30) begin
            errors++;
            $display("FAIL b2b_totals got (%0d,%0d) (%0d,%0d) (%0d,%0d) want (0,10) (1,-20) (2,30)",
                     aoc_log[6], ad_log[6], aoc_log[7], ad_log[7], aoc_log[8], ad_log[8]);
        end
    endtask

    task automatic test_reset_mid;
        logic [5:0] g, e;
        fill_tab(16'sd1);
        run_pass(4, 4, 0, 0, 3, -1);
        for (int r = 0; r < LOG; r++) begin
            g = {fv_log[r], icd_log[r], ocd_log[r], av_log[r], dn_log[r], bsy_log[r]};
            e = {r >= 1 && r <= 3, 4'b0000, r >= 1 && r <= 3};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL abort_flags cycle %0d got %b want %b", r, g, e);
            end
        end
        checks++;
        if (ics_log[4] !== 8'd0 || ocs_log[4] !== 8'd0 || aoc_log[4] !== 8'd0 ||
            ad_log[4] !== 32'sd0) begin
            errors++;
            $display("FAIL abort_outputs got ic %0d oc %0d aoc %0d data %0d want 0",
                     ics_log[4], ocs_log[4], aoc_log[4], ad_log[4]);
        end
        val_tab[0][0] = 16'sd1;
        val_tab[0][1] = 16'sd2;
        val_tab[1][0] = 16'sd3;
        val_tab[1][1] = 16'sd4;
        run_pass(2, 2, 0, 0, -1, -1);
        for (int r = 0; r < LOG; r++) begin
            g = {fv_log[r], icd_log[r], ocd_log[r], av_log[r], dn_log[r], bsy_log[r]};
            e = {r >= 1 && r <= 4, r == 2 || r == 4, r == 4, r == 7 || r == 9, r == 10,
                 r >= 1 && r <= 10};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL fresh_flags cycle %0d got %b want %b", r, g, e);
            end
        end
        checks++;
        if (aoc_log[7] !== 8'd0 || ad_log[7] !== 32'sd3 || aoc_log[9] !== 8'd1 ||
            ad_log[9] !== 32'sd7) begin
            errors++;
            $display("FAIL fresh_totals got (%0d,%0d) (%0d,%0d) want (0,3) (1,7)",
                     aoc_log[7], ad_log[7], aoc_log[9], ad_log[9]);
        end
    endtask

    task automatic test_overflow;
        logic signed [15:0] want_n;
`ifdef SCHED_SATURATE_EN
        want_n = 16'sd32767;
`else
        want_n = -16'sd5536;
`endif
        fill_tab(16'sd20000);
        run_pass(3, 1, 0, 0, -1, -1);
        checks++;
        if (av_log[8] !== 1'b1 || dn_log[9] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_timing got acc_valid %b done %b want 1 1", av_log[8], dn_log[9]);
        end
        checks++;
        if (ad_log[8] !== 32'sd60000) begin
            errors++;
            $display("FAIL ovf_wide got %0d want 60000", ad_log[8]);
        end
        checks++;
        if (adn_log[8] !== want_n) begin
            errors++;
            $display("FAIL ovf_narrow got %0d want %0d", adn_log[8], want_n);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_signed;
        test_zero;
        test_back_to_back;
        test_reset_mid;
        test_overflow;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
